// File: rtl/custom_inputs.sv
`default_nettype none
// ============================================================================
// Module      : custom_inputs
// Description : Avalon-MM slave sampling board push-buttons and DIP switches:
//               synchronise, debounce, latch selected edges, raise level irq.
// Revision    : 1.0 - initial release
// ============================================================================
module custom_inputs #(
    parameter int               WIDTH           = 6,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = WIDTH'(6'b000011)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       avs_s0_address,
    input  logic             avs_s0_read,
    input  logic             avs_s0_write,
    input  logic [31:0]      avs_s0_writedata,
    output logic [31:0]      avs_s0_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] inputs_conduit
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd1;
    localparam logic [1:0] c_ADDR_EDGE = 2'd2;
    localparam logic [1:0] c_ADDR_POL  = 2'd3;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_pol;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb_load;
    logic [WIDTH-1:0] w_deb_next;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rd_sel;
    logic             w_unused;

    assign w_wdata  = avs_s0_writedata[WIDTH-1:0];
    assign w_unused = ^avs_s0_writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= inputs_conduit;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // The counter only advances while the synchronised pin disagrees with the
    // debounced level, so any agreeing cycle restarts the stability window.
    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_debounce
            logic [c_CNT_W-1:0] r_cnt;
            logic               w_diff;

            assign w_diff        = w_sync[b] != r_deb[b];
            assign w_deb_load[b] = w_diff && (r_cnt == c_CNT_LAST);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!w_diff || (r_cnt == c_CNT_LAST)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    endgenerate

    assign w_deb_next = (r_deb & ~w_deb_load) | (w_sync & w_deb_load);

    // Rising edges captured where EDGE_POL is 0, falling edges where it is 1.
    assign w_evt = ((w_deb_next & ~r_deb) & ~r_pol) |
                   ((~w_deb_next & r_deb) & r_pol);

    assign w_clr = (avs_s0_write && (avs_s0_address == c_ADDR_EDGE)) ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb  <= RESET_VALUE;
            r_mask <= '0;
            r_edge <= '0;
            r_pol  <= '0;
            irq    <= 1'b0;
        end else begin
            r_deb  <= w_deb_next;
            r_edge <= (r_edge & ~w_clr) | w_evt;
            irq    <= |(r_edge & r_mask);
            if (avs_s0_write && (avs_s0_address == c_ADDR_MASK)) begin
                r_mask <= w_wdata;
            end
            if (avs_s0_write && (avs_s0_address == c_ADDR_POL)) begin
                r_pol <= w_wdata;
            end
        end
    end

    always_comb begin
        w_rd_sel = '0;
        case (avs_s0_address)
            c_ADDR_DATA: w_rd_sel[WIDTH-1:0] = r_deb;
            c_ADDR_MASK: w_rd_sel[WIDTH-1:0] = r_mask;
            c_ADDR_EDGE: w_rd_sel[WIDTH-1:0] = r_edge;
            c_ADDR_POL:  w_rd_sel[WIDTH-1:0] = r_pol;
            default:     w_rd_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_s0_readdata <= '0;
        end else begin
            avs_s0_readdata <= avs_s0_read ? w_rd_sel : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_custom_inputs.sv
`default_nettype none
// ============================================================================
// Module      : tb_custom_inputs
// Description : Scoreboard bench for custom_inputs (WIDTH=6, 2 sync, 8 debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_custom_inputs;

    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       avs_s0_address;
    logic             avs_s0_read;
    logic             avs_s0_write;
    logic [31:0]      avs_s0_writedata;
    logic [31:0]      avs_s0_readdata;
    logic             irq;
    logic [WIDTH-1:0] inputs_conduit;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q  [$];
    string       name_q [$];
    logic        rd_pend = 1'b0;

    custom_inputs #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .RESET_VALUE     (6'b000011)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_readdata  (avs_s0_readdata),
        .irq              (irq),
        .inputs_conduit   (inputs_conduit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_pend <= avs_s0_read;

    // Read-data monitor: one expected word per issued read strobe.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        string       nm;
        if (rd_pend) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: readdata=0x%0h with no expected value", avs_s0_readdata);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (avs_s0_readdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: readdata=0x%0h expected 0x%0h", nm, avs_s0_readdata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        n_tests++;
        if (irq !== exp) begin
            n_fail++;
            $display("FAIL %s: irq=%b expected %b", nm, irq, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        avs_s0_read    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        tick();
        avs_s0_write     = 1'b0;
    endtask

    task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        avs_s0_read      = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        avs_s0_write     = 1'b0;
        avs_s0_read      = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        inputs_conduit   = 6'b000011;
        avs_s0_address   = 2'd0;
        avs_s0_read      = 1'b0;
        avs_s0_write     = 1'b0;
        avs_s0_writedata = 32'd0;
        repeat (3) tick();
        chk_irq(1'b0, "rst_irq_during");
        reset = 1'b0;

        rd(2'd0, 32'h3, "rst_data");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_edge");
        rd(2'd3, 32'h0, "rst_pol");
        chk_irq(1'b0, "rst_irq_after");

        // 7-cycle glitch on bit2 must be rejected
        inputs_conduit[2] = 1'b1;
        repeat (7) tick();
        inputs_conduit[2] = 1'b0;
        repeat (20) tick();
        rd(2'd0, 32'h3, "rej_data");
        rd(2'd2, 32'h0, "rej_edge");

        // Stable rise on bit2: DATA changes after edge k+9
        inputs_conduit[2] = 1'b1;
        repeat (9) tick();
        rd(2'd0, 32'h3, "acc_data_before");
        rd(2'd0, 32'h7, "acc_data_after");
        rd(2'd2, 32'h4, "acc_edge");
        chk_irq(1'b0, "acc_irq_masked");

        // Falling edge on button 0 with interrupt enabled
        wr(2'd3, 32'h3);
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h4);
        rd(2'd2, 32'h0, "fall_edge_cleared");
        inputs_conduit[0] = 1'b0;
        repeat (9) tick();
        tick();
        chk_irq(1'b0, "fall_irq_at_capture");
        tick();
        chk_irq(1'b1, "fall_irq_after");
        rd(2'd2, 32'h1, "fall_edge");
        wr(2'd2, 32'h1);
        chk_irq(1'b1, "fall_irq_write_edge");
        tick();
        chk_irq(1'b0, "fall_irq_cleared");

        // W1C on the very edge the capture happens: set wins
        inputs_conduit[0] = 1'b1;
        repeat (20) tick();
        rd(2'd2, 32'h0, "coll_rise_ignored");
        inputs_conduit[0] = 1'b0;
        repeat (9) tick();
        wr(2'd2, 32'h1);
        tick();
        chk_irq(1'b1, "coll_irq");
        rd(2'd2, 32'h1, "coll_edge");
        wr(2'd2, 32'h1);
        tick();
        chk_irq(1'b0, "coll_irq_cleared");

        // Masked capture on bit1, then unmask, then read/write collision
        wr(2'd1, 32'h0);
        inputs_conduit[1] = 1'b0;
        repeat (20) tick();
        chk_irq(1'b0, "mask_irq_off");
        rd(2'd2, 32'h2, "mask_edge");
        wr(2'd1, 32'h2);
        chk_irq(1'b0, "mask_irq_write_edge");
        tick();
        chk_irq(1'b1, "mask_irq_on");
        rw(2'd1, 32'h0, 32'h2, "rw_pre_write");
        rd(2'd1, 32'h0, "rw_post_write");
        tick();
        chk_irq(1'b0, "rw_irq_off");

        tick();
        tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_outstanding: %0d reads unanswered, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
